// File: rtl/bsmodred.sv
// rtl/bsmodred.sv - bit-serial modular reducer: LSB-first ILEN-bit frame in, (X mod MOD) out LSB-first.
// Optional frame-error pulse output enabled by macro BSMODRED_FERR_EN.
module bsmodred #(
  parameter int ILEN = 10,
  parameter int OLEN = 5,
  parameter int MOD  = 29
) (
  input  logic clk,
  input  logic reset,
  input  logic i,
  input  logic isync,
  output logic q,
  output logic osync
`ifdef BSMODRED_FERR_EN
  ,output logic ferr
`endif
);

  localparam int KW = $clog2(ILEN + 1);
  localparam int CW = (OLEN > 1) ? $clog2(OLEN) : 1;
  localparam logic [OLEN:0]   MOD_W = (OLEN + 1)'(MOD);
  localparam logic [OLEN-1:0] MOD_O = OLEN'(MOD);

  typedef enum logic {IDLE, ACC} state_t;

  state_t          state_q, state_d;
  logic [OLEN-1:0] r_q, r_d, w_q, w_d, sh_q, sh_d;
  logic [KW-1:0]   k_q, k_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            q_q, q_d, osync_q, osync_d;

  logic            acc, last;
  logic [OLEN-1:0] r_base, w_base, r_new, w_new;
  logic [KW-1:0]   k_base;
  logic [OLEN:0]   sum, dbl;

  // An isync restarts from the reset-like base (r=0, w=1, k=0) so the same
  // add/double step produces r = i and w = 2 mod MOD for bit 0.
  always_comb begin
    acc    = isync || (state_q == ACC);
    r_base = isync ? '0 : r_q;
    w_base = isync ? OLEN'(1) : w_q;
    k_base = isync ? '0 : k_q;
    sum    = {1'b0, r_base} + (i ? {1'b0, w_base} : '0);
    dbl    = {w_base, 1'b0};
    r_new  = (sum >= MOD_W) ? (sum[OLEN-1:0] - MOD_O) : sum[OLEN-1:0];
    w_new  = (dbl >= MOD_W) ? (dbl[OLEN-1:0] - MOD_O) : dbl[OLEN-1:0];
    last   = acc && (k_base == KW'(ILEN - 1));
    r_d    = r_q;
    w_d    = w_q;
    k_d    = k_q;
    if (last) begin
      r_d = '0;
      w_d = OLEN'(1);
      k_d = '0;
    end else if (acc) begin
      r_d = r_new;
      w_d = w_new;
      k_d = k_base + KW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (last)     state_d = IDLE;
    else if (acc) state_d = ACC;
  end

  // Output shifter runs independently so frame N drains while N+1 accumulates.
  always_comb begin
    q_d     = 1'b0;
    osync_d = 1'b0;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    if (last) begin
      q_d     = r_new[0];
      osync_d = 1'b1;
      sh_d    = r_new >> 1;
      cnt_d   = CW'(OLEN - 1);
    end else if (cnt_q != '0) begin
      q_d   = sh_q[0];
      sh_d  = sh_q >> 1;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q     <= '0;
      w_q     <= OLEN'(1);
      k_q     <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      osync_q <= 1'b0;
    end else begin
      r_q     <= r_d;
      w_q     <= w_d;
      k_q     <= k_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      osync_q <= osync_d;
    end
  end

  assign q     = q_q;
  assign osync = osync_q;

`ifdef BSMODRED_FERR_EN
  logic ferr_q;

  always_ff @(posedge clk) begin
    if (reset) ferr_q <= 1'b0;
    else       ferr_q <= isync && (state_q == ACC);
  end

  assign ferr = ferr_q;
`endif

endmodule

// File: tb/tb_bsmodred.sv
// tb/tb_bsmodred.sv - scoreboard bench for bsmodred (ILEN=10, OLEN=5, MOD=29).
module tb_bsmodred;

  localparam int ILEN = 10;
  localparam int OLEN = 5;
  localparam int MOD  = 29;

  logic clk, reset, i, isync, q, osync;
`ifdef BSMODRED_FERR_EN
  logic ferr;
  int   ferr_cycles[$];
`endif

  typedef struct {
    int res;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   nchk = 0;
  int   nerr = 0;
  int   cyc  = 0;
  bit   mon_en = 0;

  bsmodred #(.ILEN(ILEN), .OLEN(OLEN), .MOD(MOD)) dut (
    .clk   (clk),
    .reset (reset),
    .i     (i),
    .isync (isync),
    .q     (q),
    .osync (osync)
`ifdef BSMODRED_FERR_EN
    ,.ferr (ferr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    nchk++;
    if (act != expv) begin
      nerr++;
      $display("FAIL %s at cycle %0d: actual=%0d expected=%0d", name, cyc, act, expv);
    end
  endtask

  task automatic partial(input logic [ILEN-1:0] x, input int n);
    for (int b = 0; b < n; b++) begin
      i     = x[b];
      isync = (b == 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [ILEN-1:0] x, input int res);
    for (int b = 0; b < ILEN; b++) begin
      i     = x[b];
      isync = (b == 0);
      if (b == 0) exp_q.push_back('{res: res, cyc: cyc + ILEN});
      @(posedge clk); #1;
    end
    isync = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      i     = 1'($urandom);
      isync = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // Monitor: collects each osync window and compares against the scoreboard.
  exp_t            cur;
  logic [OLEN-1:0] got;
  int              nbits = 0;
  bit              collecting = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (osync) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_osync", 1, 0);
          collecting = 0;
        end else begin
          cur = exp_q.pop_front();
          chk("osync_cycle", cyc, cur.cyc);
          got        = '0;
          got[0]     = q;
          nbits      = 1;
          collecting = 1;
        end
      end else if (collecting) begin
        got[nbits] = q;
        nbits++;
      end else begin
        chk("q_idle", int'(q), 0);
      end
      if (collecting && nbits == OLEN) begin
        chk("residue", int'(got), cur.res);
        collecting = 0;
      end
`ifdef BSMODRED_FERR_EN
      begin
        int fe = 0;
        foreach (ferr_cycles[n]) if (ferr_cycles[n] == cyc) fe = 1;
        chk("ferr", int'(ferr), fe);
      end
`endif
    end
  end

  int dir_x[4]   = '{10'h3E0, 10'h3FF, 10'h01D, 10'h000};
  int dir_r[4]   = '{6, 8, 0, 0};
  int b2b_r[10]  = '{16, 3, 19, 6, 22, 9, 25, 12, 28, 15};

  initial begin
    reset = 1'b1;
    i     = 1'b0;
    isync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_q", int'(q), 0);
    chk("reset_osync", int'(osync), 0);
    @(posedge clk); #1;
    reset  = 1'b0;
    mon_en = 1;
    idle(3);

    send_frame(10'h010, 16);
    idle(12);

    for (int n = 0; n < 4; n++) begin
      send_frame(ILEN'(dir_x[n]), dir_r[n]);
      idle(12);
    end

    for (int a = 1; a <= 10; a++) send_frame(ILEN'(16 * a), b2b_r[a-1]);
    idle(12);

    // Abort after 4 bits; the restarted frame is the only output.
`ifdef BSMODRED_FERR_EN
    ferr_cycles.push_back(cyc + 5);
`endif
    partial(10'h155, 4);
    send_frame(10'h3FF, 8);
    idle(12);

    // isync lands exactly where the final bit of the old frame was due.
`ifdef BSMODRED_FERR_EN
    ferr_cycles.push_back(cyc + 10);
`endif
    partial(10'h2AA, 9);
    send_frame(10'h3E0, 6);
    idle(12);

    // Reset mid-frame with a simultaneous isync: nothing may come out.
    partial(10'h3FF, 6);
    reset = 1'b1;
    i     = 1'b1;
    isync = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    isync = 1'b0;
    idle(15);
    send_frame(10'h3E0, 6);
    idle(12);

    for (int x = 0; x < (1 << ILEN); x++) send_frame(ILEN'(x), x % MOD);
    idle(12);

    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge clk);
    chk("drain_pending", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
